addsub_share_arbiter: RTL



---
 rtl/addsub_share_arbiter_pkg.sv | 41 ++++
 rtl/addsub_share_arbiter_if.sv | 29 ++
 rtl/addsub_share_arbiter_rr_grant.sv | 38 +++
 rtl/bit_adder.sv | 26 ++
 rtl/addsub_share_arbiter.sv | 93 +++++++++
 5 files changed

// File: rtl/addsub_share_arbiter_pkg.sv
// Shared types and the rotate-priority pick function for the add/sub arbiter.
package addsub_arb_pkg;

    localparam int NREQ_DEF = 4;
    localparam int NREQ_MAX = 8;
    localparam int IDW_MAX  = 3;

    // Result of a round-robin scan: index of the winner and whether one exists.
    typedef struct packed {
        logic               found;
        logic [IDW_MAX-1:0] idx;
    } pick_t;

    // Contents of the single response slot.
    typedef struct packed {
        logic [IDW_MAX-1:0] id;
        logic [7:0]         s;
        logic               overflow;
        logic               carry;
    } rsp_t;

    // First set bit of valid[n-1:0], scanning ptr, ptr+1, ... modulo n.
    function automatic pick_t rr_pick(input logic [NREQ_MAX-1:0] valid,
                                      input logic [IDW_MAX-1:0]  ptr,
                                      input int                  n);
        pick_t r;
        int    j;
        r = '0;
        for (int k = 0; k < NREQ_MAX; k++) begin
            if (k < n) begin
                j = (int'(ptr) + k) % n;
                if (!r.found && valid[j]) begin
                    r.found = 1'b1;
                    r.idx   = IDW_MAX'(j);
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/addsub_share_arbiter_if.sv
// Request/response bundle between the requesters and the shared add/sub arbiter.
interface addsub_share_arbiter_if
    import addsub_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    localparam int IDW = $clog2(NREQ)
);
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*8-1:0] req_x;
    logic [NREQ*8-1:0] req_y;
    logic [NREQ-1:0]   req_sub;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [7:0]        rsp_s;
    logic              rsp_overflow;
    logic              rsp_carry;

    modport master (
        output req_valid, req_x, req_y, req_sub, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_s, rsp_overflow, rsp_carry
    );

    modport slave (
        input  req_valid, req_x, req_y, req_sub, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_s, rsp_overflow, rsp_carry
    );
endinterface

// File: rtl/addsub_share_arbiter_rr_grant.sv
// Combinational rotate-priority picker: one-hot grant starting the scan at ptr.
module rr_grant
    import addsub_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    localparam int IDW = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_valid,
    input  logic [IDW-1:0]  ptr,
    input  logic            enable,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  idx,
    output logic            found
);
    logic [NREQ_MAX-1:0] valid_pad;
    pick_t               pick;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ_MAX; gi++) begin : g_pad
            if (gi < NREQ) begin : g_real
                assign valid_pad[gi] = req_valid[gi];
            end else begin : g_zero
                assign valid_pad[gi] = 1'b0;
            end
        end
    endgenerate

    assign pick  = rr_pick(valid_pad, IDW_MAX'(ptr), NREQ);
    assign found = enable & pick.found;
    assign idx   = pick.idx[IDW-1:0];

    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_onehot
            assign grant[gi] = found & (pick.idx == IDW_MAX'(gi));
        end
    endgenerate
endmodule

// File: rtl/bit_adder.sv
// 8-bit ripple add/subtract; subtraction is X + ~Y + 1.
module bit_adder (
    input  logic [7:0] x,
    input  logic [7:0] y,
    input  logic       sub,
    output logic [7:0] s,
    output logic       overflow,
    output logic       carry
);
    logic [8:0] c;
    logic [7:0] y_eff;

    assign c[0]  = sub;
    assign y_eff = y ^ {8{sub}};

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_bit
            assign s[gi]   = x[gi] ^ y_eff[gi] ^ c[gi];
            assign c[gi+1] = (x[gi] & y_eff[gi]) | (c[gi] & (x[gi] ^ y_eff[gi]));
        end
    endgenerate

    assign overflow = c[7] ^ c[8];
    assign carry    = c[8];
endmodule

// File: rtl/addsub_share_arbiter.sv
// Round-robin sharing of one add/sub datapath with a single registered response slot.
module addsub_share_arbiter
    import addsub_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    localparam int IDW = $clog2(NREQ)
) (
    input logic                   clk,
    input logic                   rst,
    addsub_share_arbiter_if.slave bus
);
    logic [IDW-1:0]  ptr_reg, ptr_next;
    rsp_t            rsp_reg, rsp_next;
    logic            rsp_valid_reg, rsp_valid_next;
    logic            can_accept;
    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  grant_idx;
    logic            grant_found;
    logic [7:0]      x_arr [NREQ];
    logic [7:0]      y_arr [NREQ];
    logic [7:0]      sum;
    logic            ovf;
    logic            cout;
    logic            unused_id_bits;

    // The slot can take a new result if it is empty or being drained this cycle.
    assign can_accept = ~rsp_valid_reg | bus.rsp_ready;

    rr_grant #(.NREQ(NREQ)) u_rr_grant (
        .req_valid (bus.req_valid),
        .ptr       (ptr_reg),
        .enable    (can_accept & ~rst),
        .grant     (grant),
        .idx       (grant_idx),
        .found     (grant_found)
    );

    assign bus.req_ready = grant;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign x_arr[gi] = bus.req_x[gi*8 +: 8];
            assign y_arr[gi] = bus.req_y[gi*8 +: 8];
        end
    endgenerate

    bit_adder u_bit_adder (
        .x        (x_arr[grant_idx]),
        .y        (y_arr[grant_idx]),
        .sub      (bus.req_sub[grant_idx]),
        .s        (sum),
        .overflow (ovf),
        .carry    (cout)
    );

    // Next slot contents and pointer: load on grant, otherwise drain or hold.
    always_comb begin
        rsp_next       = rsp_reg;
        rsp_valid_next = rsp_valid_reg;
        ptr_next       = ptr_reg;
        if (grant_found) begin
            rsp_next.id       = IDW_MAX'(grant_idx);
            rsp_next.s        = sum;
            rsp_next.overflow = ovf;
            rsp_next.carry    = cout;
            rsp_valid_next    = 1'b1;
            ptr_next          = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + IDW'(1);
        end else if (rsp_valid_reg && bus.rsp_ready) begin
            rsp_valid_next = 1'b0;
        end
    end

    // Slot and pointer registers; reset drops any pending result at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_reg       <= '0;
            rsp_valid_reg <= 1'b0;
            ptr_reg       <= '0;
        end else begin
            rsp_reg       <= rsp_next;
            rsp_valid_reg <= rsp_valid_next;
            ptr_reg       <= ptr_next;
        end
    end

    assign bus.rsp_valid    = rsp_valid_reg;
    assign bus.rsp_id       = rsp_reg.id[IDW-1:0];
    assign bus.rsp_s        = rsp_reg.s;
    assign bus.rsp_overflow = rsp_reg.overflow;
    assign bus.rsp_carry    = rsp_reg.carry;
    assign unused_id_bits   = ^rsp_reg.id;
endmodule
